// File: rtl/finv_table_gen.sv
// Writer for the 2048-word reciprocal table: per segment, secant gradient and intercept as IEEE singles.
// Optional FINV_TABLE_GEN_AUTOSTART_EN: start a generation run automatically once reset releases.
module finv_table_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        wr_en,
  output logic [10:0] wr_addr,
  output logic [31:0] wr_data
);

  typedef enum logic [2:0] {IDLE, DIV0, DIV, CONV, WR_G, WR_S} state_t;

  state_t      state, state_nx;
  logic [9:0]  h;
  logic [4:0]  cnt;
  logic [11:0] rem, rem_nx, divisor;
  logic [12:0] shifted;
  logic [24:0] q;
  logic [25:0] q_nx, r0, r1;
  logic        ge, div_last, go;

`ifdef FINV_TABLE_GEN_AUTOSTART_EN
  logic auto_pend;
  always_ff @(posedge clk) auto_pend <= rst;
  assign go = start | auto_pend;
`else
  assign go = start;
`endif

  // Restoring divide of 2^35 by A: the top dividend bits leave 512 as the initial remainder.
  assign divisor  = 12'd1024 + {2'b00, h} + {11'd0, state == DIV};
  assign shifted  = {(cnt == 5'd0) ? 12'd512 : rem, 1'b0};
  assign ge       = shifted >= {1'b0, divisor};
  assign rem_nx   = ge ? 12'(shifted - {1'b0, divisor}) : shifted[11:0];
  assign q_nx     = {(cnt == 5'd0) ? 25'd0 : q, ge};
  assign div_last = cnt == 5'd25;

  logic [14:0] d;
  logic [10:0] a;
  logic [26:0] g, s, conv_in;
  logic [4:0]  p;
  logic [22:0] mant;
  logic [31:0] fp_word;

  assign d = 15'(r0 - r1);
  assign a = {1'b1, h};
  assign g = {2'b00, d, 10'd0};
  assign s = {1'b0, r0} + 27'({12'd0, d} * {16'd0, a});
  assign conv_in = (state == CONV) ? g : s;

  // One converter serves both words: G in CONV, S in WR_G.
  always_comb begin
    p = 5'd0;
    for (int i = 0; i < 27; i++)
      if (conv_in[i]) p = 5'(i);
    if (p >= 5'd23) mant = 23'(conv_in >> (p - 5'd23));
    else            mant = 23'(conv_in << (5'd23 - p));
    fp_word = (conv_in == 27'd0) ? 32'd0 : {1'b0, 8'd103 + {3'd0, p}, mant};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go) state_nx = DIV0;
      DIV0:    if (div_last) state_nx = DIV;
      DIV:     if (div_last) state_nx = CONV;
      CONV:    state_nx = WR_G;
      WR_G:    state_nx = WR_S;
      WR_S:    state_nx = (h == 10'd1023) ? IDLE : DIV;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy  = state != IDLE;
    wr_en = (state == WR_G) || (state == WR_S);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0; cnt <= '0; rem <= '0; q <= '0; r0 <= '0; r1 <= '0;
      done <= 1'b0; wr_addr <= '0; wr_data <= '0;
    end else begin
      case (state)
        IDLE: if (go) begin
          done <= 1'b0;
          h    <= '0;
        end
        DIV0, DIV: begin
          rem <= rem_nx;
          q   <= q_nx[24:0];
          cnt <= div_last ? 5'd0 : cnt + 5'd1;
          if (div_last) begin
            if (state == DIV0) r0 <= q_nx;
            else               r1 <= q_nx;
          end
        end
        CONV: begin
          wr_addr <= {h, 1'b0};
          wr_data <= fp_word;
        end
        WR_G: begin
          wr_addr <= {h, 1'b1};
          wr_data <= fp_word;
        end
        WR_S: begin
          // R(A+1) of this segment is R(A) of the next one.
          r0   <= r1;
          h    <= h + 10'd1;
          done <= h == 10'd1023;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_finv_table_gen.sv
// Self-checking bench for finv_table_gen: reference table from the secant formulas, write-log scoreboard.
module tb_finv_table_gen;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic        busy, done, wr_en;
  logic [10:0] wr_addr;
  logic [31:0] wr_data;

  finv_table_gen dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges++;

  int checks = 0, passed = 0;
  logic [31:0] ref_tab [2048];

  typedef struct { int cyc; logic [10:0] addr; logic [31:0] data; } wr_t;
  wr_t log_q [$];
  always @(negedge clk) if (wr_en === 1'b1) log_q.push_back('{edges, wr_addr, wr_data});

  function automatic logic [31:0] to_float(input longint x);
    int p = 0;
    longint m;
    if (x == 0) return 32'd0;
    while ((x >> (p + 1)) != 0) p++;
    m = ((x << 23) >> p) & 64'h7FFFFF;
    return {1'b0, 8'(103 + p), 23'(m)};
  endfunction

  function automatic int exp_cyc(input int i);
    return 54 + (i / 2) * 29 + (i % 2);
  endfunction

  task automatic build_model();
    for (int h = 0; h < 1024; h++) begin
      longint a  = 1024 + h;
      longint r0 = (64'sd1 << 35) / a;
      longint r1 = (64'sd1 << 35) / (a + 1);
      longint dd = r0 - r1;
      ref_tab[2*h]   = to_float(dd * 1024);
      ref_tab[2*h+1] = to_float(r0 + dd * a);
    end
  endtask

  task automatic check_outputs_reset(input string tag);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0 || wr_addr !== 11'd0 || wr_data !== 32'd0)
      $display("FAIL %s: busy=%b done=%b wr_en=%b addr=%0d data=%h, want all zero",
               tag, busy, done, wr_en, wr_addr, wr_data);
    else passed++;
  endtask

  // Compare logged writes (relative to start cycle n0) against the model up to limit_rel.
  task automatic check_log(input string tag, input int n0, input int limit_rel);
    int exp_n = 0;
    for (int i = 0; i < 2048; i++) if (exp_cyc(i) <= limit_rel) exp_n++;
    checks++;
    if (log_q.size() != exp_n) $display("FAIL %s count: got %0d writes, want %0d", tag, log_q.size(), exp_n);
    else passed++;
    for (int i = 0; i < log_q.size() && i < 2048; i++) begin
      int rel = log_q[i].cyc - n0;
      checks++;
      if (rel != exp_cyc(i) || log_q[i].addr !== 11'(i) || log_q[i].data !== ref_tab[i])
        $display("FAIL %s word %0d: cyc=%0d addr=%0d data=%h, want cyc=%0d addr=%0d data=%h",
                 tag, i, rel, log_q[i].addr, log_q[i].data, exp_cyc(i), i, ref_tab[i]);
      else passed++;
    end
  endtask

  // Issue a start and follow the run to its end; optional extra start pulses while busy.
  task automatic run_full(input string tag, input bit pulses, output int n0, output int end_rel);
    int rnd = $urandom_range(200, 29000);
    int rel;
    repeat ($urandom_range(1, 8)) @(negedge clk);
    log_q.delete();
    start = 1'b1;
    n0 = edges;
    end_rel = -1;
    for (int k = 0; k < 31000; k++) begin
      @(negedge clk);
      rel = edges - n0;
      start = pulses && (rel == 100 || rel == 5000 || rel == rnd);
      if (busy === 1'b0) begin
        end_rel = rel;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (end_rel != 29723) $display("FAIL %s run_end: busy fell at cycle %0d, want 29723", tag, end_rel);
    else passed++;
    checks++;
    if (done !== 1'b1) $display("FAIL %s done: got %b, want 1", tag, done);
    else passed++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_outputs_reset("reset");
    end
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_single_run();
    int n0, end_rel;
    run_full("single", 1'b0, n0, end_rel);
    checks++;
    if (log_q.size() < 2 || log_q[0].cyc - n0 != 54 || log_q[0].addr !== 11'd0 || log_q[0].data !== 32'h3FFFC200)
      $display("FAIL first_g: size=%0d, want addr 0 data 3fffc200 at cycle 54", log_q.size());
    else passed++;
    checks++;
    if (log_q.size() < 2 || log_q[1].cyc - n0 != 55 || log_q[1].addr !== 11'd1 || log_q[1].data !== 32'h407FE100)
      $display("FAIL first_s: size=%0d, want addr 1 data 407fe100 at cycle 55", log_q.size());
    else passed++;
    check_log("single", n0, 29722);
  endtask

  task automatic test_ignore_start();
    int n0, end_rel;
    run_full("ignore", 1'b1, n0, end_rel);
    check_log("ignore", n0, 29722);
  endtask

  task automatic test_reset_midrun();
    int n0, rel;
    repeat ($urandom_range(1, 8)) @(negedge clk);
    log_q.delete();
    start = 1'b1; n0 = edges;
    @(negedge clk);
    start = 1'b0;
    while (edges - n0 < 10000) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_reset("midrun_rst");
    rst = 1'b0;
    check_log("pre_rst", n0, 10000);
    @(negedge clk);
    check_outputs_reset("post_rst");
    log_q.delete();
    start = 1'b1; n0 = edges;
    @(negedge clk);
    start = 1'b0;
    rel = 2 + $urandom_range(2000, 3000);
    while (edges - n0 < rel) @(negedge clk);
    check_log("restart", n0, edges - n0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

`ifdef FINV_TABLE_GEN_AUTOSTART_EN
  task automatic test_autostart();
    int n0, end_rel = -1;
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    log_q.delete();
    rst = 1'b0; n0 = edges;
    for (int k = 0; k < 31000; k++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        end_rel = edges - n0;
        break;
      end
    end
    checks++;
    if (end_rel != 29723) $display("FAIL autostart run_end: got %0d, want 29723", end_rel);
    else passed++;
    check_log("autostart", n0, 29722);
  endtask
`endif

  initial begin
    build_model();
    test_reset();
`ifdef FINV_TABLE_GEN_AUTOSTART_EN
    test_autostart();
`endif
    test_single_run();
    test_ignore_start();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
